// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, funct
// codes, ALU control encodings, FSM states and the decoded control word.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned PC_STEP = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_ADD   = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB   = 6'h22;
    localparam logic [OP_W-1:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_XOR = 3'b010,
        ALU_SLT = 3'b011
    } alu_op_e;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'd0,
        PC_BEQ  = 3'd1,
        PC_BNE  = 3'd2,
        PC_JUMP = 3'd3,
        PC_JR   = 3'd4
    } pc_sel_e;

    typedef enum logic [2:0] {
        S_IFETCH    = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_e;

    typedef struct packed {
        logic    reg_wr;
        logic    reg_dst;
        logic    alu_src;
        alu_op_e alu_cntrl;
        logic    mem_wr;
        logic    mem_to_reg;
        logic    jl;
        pc_sel_e pc_sel;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct -> control word + legal flag.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    output ctrl_t           ctrl,
    output logic            legal
);

    // Unsupported encodings fall out as an all-zero control word (a NOP).
    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        ctrl.reg_dst   = 1'b1;
                        ctrl.alu_src   = 1'b1;
                        ctrl.alu_cntrl = ALU_ADD;
                        ctrl.reg_wr    = 1'b1;
                    end
                    FN_SUB: begin
                        ctrl.reg_dst   = 1'b1;
                        ctrl.alu_src   = 1'b1;
                        ctrl.alu_cntrl = ALU_SUB;
                        ctrl.reg_wr    = 1'b1;
                    end
                    FN_SLT: begin
                        ctrl.reg_dst   = 1'b1;
                        ctrl.alu_src   = 1'b1;
                        ctrl.alu_cntrl = ALU_SLT;
                        ctrl.reg_wr    = 1'b1;
                    end
                    FN_JR:   ctrl.pc_sel = PC_JR;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ctrl.alu_cntrl = ALU_ADD;
                ctrl.reg_wr    = 1'b1;
            end
            OP_XORI: begin
                ctrl.alu_cntrl = ALU_XOR;
                ctrl.reg_wr    = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_cntrl  = ALU_ADD;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_wr     = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_cntrl = ALU_ADD;
                ctrl.mem_wr    = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_cntrl = ALU_SUB;
                ctrl.pc_sel    = PC_BEQ;
            end
            OP_BNE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_cntrl = ALU_SUB;
                ctrl.pc_sel    = PC_BNE;
            end
            OP_J:    ctrl.pc_sel = PC_JUMP;
            OP_JAL: begin
                ctrl.jl     = 1'b1;
                ctrl.reg_wr = 1'b1;
                ctrl.pc_sel = PC_JUMP;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: owns PC, IR and instret, sequences
// IFETCH/DECODE/EXECUTE/WRITEBACK per instruction and drives the datapath
// control word. Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap unsupported
// instructions into a terminal HALT state instead of executing them as NOPs.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        RegWr,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic [2:0]  ALUCntrl,
    output logic        MemWr,
    output logic        MemToReg,
    output logic        jl,
    output logic [31:0] pcStore,
    input  logic        zero,
    input  logic [31:0] jRrs,
    output logic        halted,
    output logic [31:0] instret
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_store_q, pc_next, br_off;
    logic [25:0] ir_q;
    ctrl_t       ctrl_q, dec_ctrl;
    logic        dec_legal, legal_q;
    logic        zero_q, reg_wr_q, mem_wr_q;
    logic [31:0] instret_q;
    logic        ld_ir, ld_zero, ld_str, retire;

    // Decode the word as it arrives so the control word is registered
    // together with IR and is already stable for the whole EXECUTE cycle.
    mips_ctrl_decode u_decode (
        .op    (imem_data[31:26]),
        .funct (imem_data[5:0]),
        .ctrl  (dec_ctrl),
        .legal (dec_legal)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IFETCH;
        else       state_q <= state_d;
    end

    // Next-state and per-state load enables.
    always_comb begin
        state_d = state_q;
        ld_ir   = 1'b0;
        ld_zero = 1'b0;
        ld_str  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IFETCH:    state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_EXECUTE;
                ld_ir   = 1'b1;
            end
            S_EXECUTE: begin
                ld_zero = 1'b1;
                state_d = S_WRITEBACK;
                ld_str  = 1'b1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                if (!legal_q) begin
                    state_d = S_HALT;
                    ld_str  = 1'b0;
                end
`endif
            end
            S_WRITEBACK: begin
                state_d = S_IFETCH;
                retire  = 1'b1;
            end
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IFETCH;
        endcase
    end

    // Next PC for the instruction in WRITEBACK; pc_store_q already holds PC+4.
    always_comb begin
        br_off  = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        pc_next = pc_store_q;
        case (ctrl_q.pc_sel)
            PC_BEQ:  if (zero_q)  pc_next = pc_store_q + br_off;
            PC_BNE:  if (!zero_q) pc_next = pc_store_q + br_off;
            PC_JUMP: pc_next = {pc_store_q[31:28], ir_q[25:0], 2'b00};
            PC_JR:   pc_next = jRrs;
            default: pc_next = pc_store_q;
        endcase
    end

    // PC, IR, control word, strobes and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pc_store_q <= RESET_PC + 32'(PC_STEP);
            ir_q       <= '0;
            ctrl_q     <= '0;
            legal_q    <= 1'b1;
            zero_q     <= 1'b0;
            reg_wr_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            instret_q  <= '0;
        end else begin
            reg_wr_q <= ld_str & ctrl_q.reg_wr;
            mem_wr_q <= ld_str & ctrl_q.mem_wr;
            if (ld_zero) zero_q <= zero;
            if (ld_ir) begin
                ir_q    <= imem_data[25:0];
                ctrl_q  <= dec_ctrl;
                legal_q <= dec_legal;
            end else if (retire) begin
                ctrl_q  <= '0;
            end
            if (retire) begin
                pc_q       <= pc_next;
                pc_store_q <= pc_next + 32'(PC_STEP);
                instret_q  <= instret_q + 32'd1;
            end
        end
    end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic halted_q;

    // Trap flag tracks entry into HALT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= (state_d == S_HALT);
    end

    assign halted = halted_q;
`else
    logic unused_legal;
    assign unused_legal = legal_q;
    assign halted       = 1'b0;
`endif

    assign imem_addr = pc_q;
    assign pcStore   = pc_store_q;
    assign instret   = instret_q;
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign imm16     = ir_q[15:0];
    assign RegWr     = reg_wr_q;
    assign MemWr     = mem_wr_q;
    assign RegDst    = ctrl_q.reg_dst;
    assign ALUSrc    = ctrl_q.alu_src;
    assign ALUCntrl  = ctrl_q.alu_cntrl;
    assign MemToReg  = ctrl_q.mem_to_reg;
    assign jl        = ctrl_q.jl;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: drives instruction words and
// datapath feedback, checks the control word, strobes, PC and instret.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_data;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        RegWr, RegDst, ALUSrc, MemWr, MemToReg, jl, zero, halted;
    logic [2:0]  ALUCntrl;
    logic [31:0] pcStore, jRrs, instret;

    int checks = 0;
    int errors = 0;

    mips_multicycle_control #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm16     (imm16),
        .RegWr     (RegWr),
        .RegDst    (RegDst),
        .ALUSrc    (ALUSrc),
        .ALUCntrl  (ALUCntrl),
        .MemWr     (MemWr),
        .MemToReg  (MemToReg),
        .jl        (jl),
        .pcStore   (pcStore),
        .zero      (zero),
        .jRrs      (jRrs),
        .halted    (halted),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // From IFETCH: present the word and feedback, stop in EXECUTE.
    task automatic to_exec(input logic [31:0] instr, input logic z, input logic [31:0] r);
        imem_data = instr;
        zero      = z;
        jRrs      = r;
        step();
        step();
    endtask

    // Whole instruction, ending in the next IFETCH.
    task automatic run(input logic [31:0] instr, input logic z, input logic [31:0] r);
        to_exec(instr, z, r);
        step();
        step();
    endtask

    initial begin
        reset     = 1'b1;
        imem_data = 32'h0;
        zero      = 1'b0;
        jRrs      = 32'h0;
        step();
        step();
        chk("rst_addr",    imem_addr, 32'h0);
        chk("rst_regwr",   32'(RegWr), 32'h0);
        chk("rst_memwr",   32'(MemWr), 32'h0);
        chk("rst_jl",      32'(jl), 32'h0);
        chk("rst_halted",  32'(halted), 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_imm16",   32'(imm16), 32'h0);
        chk("rst_pcstore", pcStore, 32'h4);
        reset = 1'b0;

        // ADDI $t0,$zero,5 at PC 0
        to_exec(32'h2008_0005, 1'b0, 32'h0);
        chk("addi_ex_regwr", 32'(RegWr), 32'h0);
        step();
        chk("addi_regwr",  32'(RegWr), 32'h1);
        chk("addi_regdst", 32'(RegDst), 32'h0);
        chk("addi_alusrc", 32'(ALUSrc), 32'h0);
        chk("addi_alu",    32'(ALUCntrl), 32'h0);
        chk("addi_rt",     32'(rt), 32'h8);
        chk("addi_memwr",  32'(MemWr), 32'h0);
        step();
        chk("addi_pc",      imem_addr, 32'h4);
        chk("addi_instret", instret, 32'h1);
        chk("addi_regwr_off", 32'(RegWr), 32'h0);

        // Advance to PC 0x10
        for (int i = 0; i < 3; i++) run(32'h2008_0005, 1'b0, 32'h0);
        chk("pc_0x10", imem_addr, 32'h10);

        // BNE not-equal at 0x10, imm -4 -> 0x04
        to_exec(32'h1509_FFFC, 1'b0, 32'h0);
        chk("bne_alusrc", 32'(ALUSrc), 32'h1);
        chk("bne_alu",    32'(ALUCntrl), 32'h1);
        step();
        chk("bne_regwr", 32'(RegWr), 32'h0);
        chk("bne_memwr", 32'(MemWr), 32'h0);
        step();
        chk("bne_taken_pc", imem_addr, 32'h4);
        chk("bne_instret",  instret, 32'h5);

        for (int i = 0; i < 3; i++) run(32'h2008_0005, 1'b0, 32'h0);
        // BNE with zero=1 is not taken -> 0x14
        run(32'h1509_FFFC, 1'b1, 32'h0);
        chk("bne_nt_pc", imem_addr, 32'h14);

        // BEQ equal at 0x14, imm 3 -> 0x18 + 12
        run(32'h1000_0003, 1'b1, 32'h0);
        chk("beq_taken_pc", imem_addr, 32'h24);

        // J to 0x20
        run(32'h0800_0008, 1'b0, 32'h0);
        chk("j_pc", imem_addr, 32'h20);

        // JAL 0x40 at 0x20 -> 0x100
        to_exec(32'h0C00_0040, 1'b0, 32'h0);
        step();
        chk("jal_jl",      32'(jl), 32'h1);
        chk("jal_regwr",   32'(RegWr), 32'h1);
        chk("jal_pcstore", pcStore, 32'h24);
        step();
        chk("jal_pc", imem_addr, 32'h100);
        chk("jal_jl_off", 32'(jl), 32'h0);

        // JR $ra with jRrs=0x24
        to_exec(32'h03E0_0008, 1'b0, 32'h24);
        step();
        chk("jr_regwr", 32'(RegWr), 32'h0);
        step();
        chk("jr_pc",      imem_addr, 32'h24);
        chk("jr_instret", instret, 32'd13);

        // SUB $3,$1,$2
        to_exec(32'h0022_1822, 1'b0, 32'h0);
        chk("sub_regdst", 32'(RegDst), 32'h1);
        chk("sub_alusrc", 32'(ALUSrc), 32'h1);
        chk("sub_alu",    32'(ALUCntrl), 32'h1);
        chk("sub_rd",     32'(rd), 32'h3);
        step();
        chk("sub_regwr", 32'(RegWr), 32'h1);
        step();

        // SLT $3,$1,$2
        to_exec(32'h0022_182A, 1'b0, 32'h0);
        chk("slt_alu", 32'(ALUCntrl), 32'h3);
        step();
        step();

        // XORI $8,$1,0xFFFF
        to_exec(32'h3828_FFFF, 1'b0, 32'h0);
        chk("xori_alu",    32'(ALUCntrl), 32'h2);
        chk("xori_alusrc", 32'(ALUSrc), 32'h0);
        chk("xori_imm",    32'(imm16), 32'hFFFF);
        step();
        chk("xori_regwr", 32'(RegWr), 32'h1);
        step();

        // LW $8,4($1)
        to_exec(32'h8C28_0004, 1'b0, 32'h0);
        chk("lw_memtoreg", 32'(MemToReg), 32'h1);
        step();
        chk("lw_regwr", 32'(RegWr), 32'h1);
        chk("lw_memwr", 32'(MemWr), 32'h0);
        step();
        chk("lw_pc",      imem_addr, 32'h34);
        chk("lw_instret", instret, 32'd17);

        // SW interrupted by reset in WRITEBACK
        to_exec(32'hAC28_0008, 1'b0, 32'h0);
        step();
        chk("sw_memwr", 32'(MemWr), 32'h1);
        chk("sw_regwr", 32'(RegWr), 32'h0);
        reset = 1'b1;
        #1;
        chk("sw_rst_memwr", 32'(MemWr), 32'h0);
        step();
        chk("sw_rst_pc",      imem_addr, 32'h0);
        chk("sw_rst_instret", instret, 32'h0);
        reset = 1'b0;

        // Opcode 0x3F
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        to_exec(32'hFC00_0000, 1'b0, 32'h0);
        step();
        chk("ill_halted", 32'(halted), 32'h1);
        chk("ill_regwr",  32'(RegWr), 32'h0);
        repeat (10) step();
        chk("ill_pc",      imem_addr, 32'h0);
        chk("ill_instret", instret, 32'h0);
        chk("ill_halted_hold", 32'(halted), 32'h1);
        chk("ill_memwr",   32'(MemWr), 32'h0);
`else
        to_exec(32'hFC00_0000, 1'b0, 32'h0);
        step();
        chk("nop_regwr", 32'(RegWr), 32'h0);
        chk("nop_memwr", 32'(MemWr), 32'h0);
        step();
        chk("nop_pc",      imem_addr, 32'h4);
        chk("nop_instret", instret, 32'h1);
        chk("nop_halted",  32'(halted), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
